// File: rtl/awg_cmd_parser.sv
// Framed UART command parser: SYNC, CMD, payload, CHK -> atomic commit of the waveform configuration.
// Define AWG_CMD_ACK_EN to add an ACK/NAK response channel (tx_data/tx_valid/tx_ready).
module awg_cmd_parser #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [1:0]  waveform_type,
    output logic [15:0] frequency,
    output logic [9:0]  amplitude,
    output logic [9:0]  dc_offset,
    output logic        cfg_update,
    output logic        err_chk,
    output logic        err_cmd,
    output logic        err_timeout,
`ifdef AWG_CMD_ACK_EN
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, CHECK} state_t;

    localparam int             TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [7:0]    code;
    logic [2:0]    cnt;
    logic [7:0]    sum;
    logic [49:0]   staging;
    logic [TW-1:0] tmr;
    logic [2:0]    cmd_len;
    logic          cmd_known;

    function automatic logic [9:0] sat10(input logic [15:0] v);
        return (|v[15:10]) ? 10'h3FF : v[9:0];
    endfunction

    function automatic logic [15:0] freq_fix(input logic [15:0] v);
        return (v == 16'h0000) ? 16'h0001 : v;
    endfunction

    always_comb begin
        cmd_len   = 3'd0;
        cmd_known = 1'b0;
        case (rx_data)
            8'h01: begin cmd_len = 3'd1; cmd_known = 1'b1; end
            8'h02, 8'h03, 8'h04: begin cmd_len = 3'd2; cmd_known = 1'b1; end
            8'h0F: begin cmd_len = 3'd7; cmd_known = 1'b1; end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    // Staging only reaches the outputs from CHECK, so partial or timed-out frames never disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            code          <= 8'h00;
            cnt           <= 3'd0;
            sum           <= 8'h00;
            staging       <= '0;
            tmr           <= '0;
            waveform_type <= 2'd0;
            frequency     <= 16'h0001;
            amplitude     <= 10'h3FF;
            dc_offset     <= 10'h200;
            cfg_update    <= 1'b0;
            err_chk       <= 1'b0;
            err_cmd       <= 1'b0;
            err_timeout   <= 1'b0;
`ifdef AWG_CMD_ACK_EN
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
`endif
        end else begin
            cfg_update  <= 1'b0;
            err_chk     <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;
`ifdef AWG_CMD_ACK_EN
            if (tx_valid && tx_ready)
                tx_valid <= 1'b0;
`endif
            if (rx_valid || state == IDLE)
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;

            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE)
                            state <= CMD;
                    end
                    CMD: begin
                        if (cmd_known) begin
                            code    <= rx_data;
                            cnt     <= cmd_len;
                            sum     <= rx_data;
                            staging <= '0;
                            state   <= PAYLOAD;
                        end else begin
                            err_cmd <= 1'b1;
                            state   <= IDLE;
`ifdef AWG_CMD_ACK_EN
                            tx_data  <= 8'h15;
                            tx_valid <= 1'b1;
`endif
                        end
                    end
                    PAYLOAD: begin
                        staging <= {staging[41:0], rx_data};
                        sum     <= sum + rx_data;
                        cnt     <= cnt - 3'd1;
                        if (cnt == 3'd1)
                            state <= CHECK;
                    end
                    CHECK: begin
                        state <= IDLE;
                        if (rx_data == sum) begin
                            cfg_update <= 1'b1;
                            case (code)
                                8'h01: waveform_type <= staging[1:0];
                                8'h02: frequency     <= freq_fix(staging[15:0]);
                                8'h03: amplitude     <= sat10(staging[15:0]);
                                8'h04: dc_offset     <= sat10(staging[15:0]);
                                8'h0F: begin
                                    waveform_type <= staging[49:48];
                                    frequency     <= freq_fix(staging[47:32]);
                                    amplitude     <= sat10(staging[31:16]);
                                    dc_offset     <= sat10(staging[15:0]);
                                end
                                default: ;
                            endcase
`ifdef AWG_CMD_ACK_EN
                            tx_data  <= 8'h06;
                            tx_valid <= 1'b1;
`endif
                        end else begin
                            err_chk <= 1'b1;
`ifdef AWG_CMD_ACK_EN
                            tx_data  <= 8'h15;
                            tx_valid <= 1'b1;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tmr == TMAX) begin
                // A byte arriving on the expiry cycle takes the branch above instead.
                err_timeout <= 1'b1;
                state       <= IDLE;
                staging     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_awg_cmd_parser.sv
// Directed, table-driven bench for awg_cmd_parser with hand-computed frames and expected configuration.
module tb_awg_cmd_parser;

    localparam int TO = 200;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [1:0]  waveform_type;
    logic [15:0] frequency;
    logic [9:0]  amplitude;
    logic [9:0]  dc_offset;
    logic        cfg_update;
    logic        err_chk;
    logic        err_cmd;
    logic        err_timeout;
    logic        busy;
`ifdef AWG_CMD_ACK_EN
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`endif

    int vectors;
    int miscompares;

    typedef struct {
        string       name;
        logic [79:0] bytes;
        int          n;
        logic [1:0]  w;
        logic [15:0] f;
        logic [9:0]  a;
        logic [9:0]  o;
        int          kind;
    } vec_t;

    vec_t vecs[$];

    logic [1:0]  cur_w;
    logic [15:0] cur_f;
    logic [9:0]  cur_a;
    logic [9:0]  cur_o;

    awg_cmd_parser #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .waveform_type(waveform_type),
        .frequency(frequency),
        .amplitude(amplitude),
        .dc_offset(dc_offset),
        .cfg_update(cfg_update),
        .err_chk(err_chk),
        .err_cmd(err_cmd),
        .err_timeout(err_timeout),
`ifdef AWG_CMD_ACK_EN
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [1:0] w, input logic [15:0] f,
                               input logic [9:0] a, input logic [9:0] o, input logic upd,
                               input logic chk, input logic cmd, input logic tmo, input logic bsy);
        vectors++;
        if ({waveform_type, frequency, amplitude, dc_offset, cfg_update, err_chk, err_cmd, err_timeout, busy}
            !== {w, f, a, o, upd, chk, cmd, tmo, bsy}) begin
            miscompares++;
            $display("[TB] FAIL %s: got w=%0d f=%h a=%h o=%h upd=%b chk=%b cmd=%b tmo=%b busy=%b; expected w=%0d f=%h a=%h o=%h upd=%b chk=%b cmd=%b tmo=%b busy=%b",
                     name, waveform_type, frequency, amplitude, dc_offset, cfg_update, err_chk, err_cmd,
                     err_timeout, busy, w, f, a, o, upd, chk, cmd, tmo, bsy);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [79:0] bytes, input int n, input logic [1:0] w,
                          input logic [15:0] f, input logic [9:0] a, input logic [9:0] o, input int kind);
        vec_t v;
        v.name = name; v.bytes = bytes; v.n = n;
        v.w = w; v.f = f; v.a = a; v.o = o; v.kind = kind;
        vecs.push_back(v);
    endtask

    task automatic sendFrame(input logic [79:0] bytes, input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(bytes[8*(n-1-k) +: 8]);
    endtask

    initial begin
        int   cycles;
        logic seen;
        vec_t v;

        vectors     = 0;
        miscompares = 0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
`ifdef AWG_CMD_ACK_EN
        tx_ready    = 1'b1;
`endif
        rst = 1'b1;
        idleCycles(2);
        checkOutput("reset", 2'd0, 16'h0001, 10'h3FF, 10'h200, 0, 0, 0, 0, 0);
        rst = 1'b0;
        idleCycles(1);

        // kind: 0 commit, 1 checksum error, 2 command error
        addVec("freq",       80'hA502123448,           5, 2'd0, 16'h1234, 10'h3FF, 10'h200, 0);
        addVec("amp",        80'hA503012327,           5, 2'd0, 16'h1234, 10'h123, 10'h200, 0);
        addVec("amp_sat",    80'hA503040007,           5, 2'd0, 16'h1234, 10'h3FF, 10'h200, 0);
        addVec("freq_zero",  80'hA502000002,           5, 2'd0, 16'h0001, 10'h3FF, 10'h200, 0);
        addVec("all",        80'hA50F020100020001556A, 10, 2'd2, 16'h0100, 10'h200, 10'h155, 0);
        addVec("all_badchk", 80'hA50F020100020001556B, 10, 2'd2, 16'h0100, 10'h200, 10'h155, 1);
        addVec("bad_cmd",    80'hA507,                 2, 2'd2, 16'h0100, 10'h200, 10'h155, 2);
        addVec("wave_wrap",  80'h0033A501FF00,         6, 2'd3, 16'h0100, 10'h200, 10'h155, 0);
        addVec("sync_data",  80'hA50400A5A9,           5, 2'd3, 16'h0100, 10'h200, 10'h0A5, 0);
        addVec("off_max",    80'hA50403FF06,           5, 2'd3, 16'h0100, 10'h200, 10'h3FF, 0);
        addVec("amp_zero",   80'hA503000003,           5, 2'd3, 16'h0100, 10'h000, 10'h3FF, 0);
        addVec("freq_max",   80'hA502FFFF00,           5, 2'd3, 16'hFFFF, 10'h000, 10'h3FF, 0);

        cur_w = 2'd0; cur_f = 16'h0001; cur_a = 10'h3FF; cur_o = 10'h200;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            for (int k = 0; k < v.n - 1; k++)
                applyStimulus(v.bytes[8*(v.n-1-k) +: 8]);
            checkOutput({v.name, "/partial"}, cur_w, cur_f, cur_a, cur_o, 0, 0, 0, 0, 1);
            applyStimulus(v.bytes[7:0]);
            checkOutput(v.name, v.w, v.f, v.a, v.o, v.kind == 0, v.kind == 1, v.kind == 2, 0, 0);
            cur_w = v.w; cur_f = v.f; cur_a = v.a; cur_o = v.o;
            idleCycles(1);
            checkOutput({v.name, "/after"}, cur_w, cur_f, cur_a, cur_o, 0, 0, 0, 0, 0);
        end

        // Inter-byte timeout: pulse exactly TO cycles after the last byte, outputs untouched.
        sendFrame(80'hA50212, 3);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 2 * TO) begin
            idleCycles(1);
            cycles++;
            if (err_timeout) seen = 1'b1;
        end
        checkValue("timeout_seen", {31'd0, seen}, 32'd1);
        checkValue("timeout_cycles", cycles, TO);
        checkOutput("timeout_state", cur_w, cur_f, cur_a, cur_o, 0, 0, 0, 1, 0);
        sendFrame(80'hA5025678D0, 5);
        cur_f = 16'h5678;
        checkOutput("post_timeout_frame", cur_w, cur_f, cur_a, cur_o, 1, 0, 0, 0, 0);

        // A byte landing on the expiry cycle keeps the frame alive.
        sendFrame(80'hA50212, 3);
        seen = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            idleCycles(1);
            if (err_timeout) seen = 1'b1;
        end
        applyStimulus(8'h34);
        if (err_timeout) seen = 1'b1;
        checkValue("expiry_byte_wins", {31'd0, seen}, 32'd0);
        applyStimulus(8'h48);
        cur_f = 16'h1234;
        checkOutput("expiry_frame_commit", cur_w, cur_f, cur_a, cur_o, 1, 0, 0, 0, 0);
        idleCycles(1);

`ifdef AWG_CMD_ACK_EN
        tx_ready = 1'b0;
        sendFrame(80'hA5010203, 4);
        cur_w = 2'd2;
        checkOutput("ack_frame", cur_w, cur_f, cur_a, cur_o, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkValue("ack_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h06});
            idleCycles(1);
        end
        tx_ready = 1'b1;
        idleCycles(1);
        checkValue("ack_cleared", {31'd0, tx_valid}, 32'd0);
        sendFrame(80'hA50F020100020001556B, 10);
        idleCycles(1);
        checkValue("nak_badchk", {23'd0, tx_valid, tx_data}, {23'd0, 1'b0, 8'h15});
`endif

        // Asynchronous reset in the middle of a frame.
        sendFrame(80'hA50F0102, 4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_midpacket", 2'd0, 16'h0001, 10'h3FF, 10'h200, 0, 0, 0, 0, 0);
        idleCycles(1);
        rst = 1'b0;
        idleCycles(1);
        sendFrame(80'hA502123448, 5);
        checkOutput("post_reset_frame", 2'd0, 16'h1234, 10'h3FF, 10'h200, 1, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/awg_cmd_parser.md
Name: awg_cmd_parser

Overview:
- Framed UART command parser and configuration sequencer for the waveform generator datapath.
- Consumes received bytes and validates sync, command, payload and checksum.
- Commits waveform_type, frequency, amplitude and dc_offset atomically only on a good packet.
- Sits between the UART RX and the phase-accumulator/DAC stage; replaces direct per-byte register writes.

Parameters:
- TIMEOUT_CYCLES, 100000: inter-byte timeout in clk cycles while mid-packet.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- rx_data  input  8  received UART byte
- rx_valid  input  1  one-cycle strobe; rx_data valid
- waveform_type  output  2  committed waveform select
- frequency  output  16  committed frequency tuning word
- amplitude  output  10  committed amplitude
- dc_offset  output  10  committed DC offset
- cfg_update  output  1  one-cycle pulse on commit
- err_chk  output  1  one-cycle pulse, checksum mismatch
- err_cmd  output  1  one-cycle pulse, unknown command
- err_timeout  output  1  one-cycle pulse, inter-byte timeout
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset values:
  - waveform_type=0, frequency=16'h0001, amplitude=10'h3FF, dc_offset=10'h200.
  - All pulses 0, busy 0, state IDLE, staging cleared.
- Frame format: SYNC, CMD, payload (MSB first), CHK. CHK = (CMD + all payload bytes) mod 256.
- Commands and payload lengths:
  - 0x01 waveform, 1 byte; waveform_type = byte[1:0], byte[7:2] ignored.
  - 0x02 frequency, 2 bytes.
  - 0x03 amplitude, 2 bytes.
  - 0x04 offset, 2 bytes.
  - 0x0F all, 7 bytes in order: wave(1), freq(2), amp(2), offset(2).
- States: IDLE -> CMD -> PAYLOAD -> CHECK -> IDLE.
  - IDLE: discard bytes other than SYNC_BYTE; on SYNC go to CMD.
  - CMD: known code -> latch code, load byte counter with payload length, init running sum, go PAYLOAD. Unknown code -> err_cmd pulse, go IDLE.
  - PAYLOAD: shift each byte into staging, add to sum, decrement counter; after the last byte go CHECK. A SYNC_BYTE value here is plain data.
  - CHECK: match -> commit; mismatch -> err_chk pulse. Either way go IDLE.
- Commit timing: outputs and cfg_update change on the clk edge after the cycle the CHK byte is strobed. Latency 1 cycle. For 0x0F all four outputs change in the same cycle.
- Width rules:
  - 16-bit amplitude/offset payload with [15:10] nonzero saturates to 10'h3FF; otherwise takes [9:0].
  - frequency payload 0 is coerced to 16'h0001.
  - Running sum is 8-bit, wraps.
- Timeout:
  - Counter reloads on every rx_valid; counts only when not IDLE.
  - Reaching TIMEOUT_CYCLES-1 -> err_timeout pulse, go IDLE, staging discarded, outputs unchanged.
  - rx_valid in the same cycle as expiry: the byte wins, no timeout.
- Outputs never change except on reset or commit. Partial packets never alter outputs.
- Reset mid-packet: immediate return to IDLE and reset values; no pulse.

Optional Feature:
- Macro AWG_CMD_ACK_EN.
- When defined, adds ports tx_data output 8, tx_valid output 1, tx_ready input 1.
  - After CHECK or a CMD error: queue ACK 8'h06 on commit, NAK 8'h15 on err_chk or err_cmd. No response on timeout.
  - tx_valid asserts the cycle after the event and holds, tx_data stable, until sampled with tx_ready high.
  - A new response while one is pending replaces it (latest wins).
  - Reset clears tx_valid.
- When undefined: no TX ports, no response logic; all other behaviour identical.

Test Plan:
- Reset check: assert rst mid-operation -> outputs 0/0x0001/0x3FF/0x200, busy=0, no pulses.
- Frequency write A5 02 12 34 48 -> frequency=0x1234 one cycle after 0x48, cfg_update single pulse, other outputs unchanged.
- Amplitude saturation: A5 03 04 00 07 -> amplitude=0x3FF. Then frequency zero, A5 02 00 00 02 -> frequency=0x0001.
- Atomic all: A5 0F 02 01 00 02 00 01 55 6A -> waveform=2, frequency=0x0100, amplitude=0x200, offset=0x155, all in one cycle. Same frame with CHK 6B -> err_chk pulse, outputs unchanged (NAK 0x15 with AWG_CMD_ACK_EN).
- Errors:
  - A5 07 -> err_cmd, back to IDLE.
  - A5 02 12 then silence TIMEOUT_CYCLES -> err_timeout, busy drops; next valid frame commits normally.
- With AWG_CMD_ACK_EN: good frame with tx_ready low for 5 cycles -> tx_valid held with tx_data=0x06, cleared the cycle after tx_ready.
